// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: op encodings, sequencer states, helpers.
package usr_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROTR = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROTL = 3'b101;
  localparam logic [MODE_W-1:0] MODE_ASR  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_ZERO = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } usr_state_e;

  // True for ops that can be repeated Amt times by the sequencer.
  function automatic logic is_multi(input logic [MODE_W-1:0] mode);
    logic multi;
    case (mode)
      MODE_SHR, MODE_SHL, MODE_ROTR, MODE_ROTL, MODE_ASR: multi = 1'b1;
      default:                                            multi = 1'b0;
    endcase
    return multi;
  endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// One bit of the universal shift register: op-selected input mux feeding a DFF.
// rsrc_i is the value this bit takes on a right-moving op (upper neighbour or edge fill),
// lsrc_i the value on a left-moving op (lower neighbour or edge fill).
module usr_bit_cell
  import usr_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic [MODE_W-1:0] op_i,
  input  logic              rsrc_i,
  input  logic              lsrc_i,
  input  logic              ld_i,
  output logic              q_o
);

  logic bit_q;
  logic bit_d;

  // Select next bit value from the effective op.
  always_comb begin
    bit_d = bit_q;
    case (op_i)
      MODE_HOLD: bit_d = bit_q;
      MODE_SHR:  bit_d = rsrc_i;
      MODE_ROTR: bit_d = rsrc_i;
      MODE_ASR:  bit_d = rsrc_i;
      MODE_SHL:  bit_d = lsrc_i;
      MODE_ROTL: bit_d = lsrc_i;
      MODE_LOAD: bit_d = ld_i;
      MODE_ZERO: bit_d = 1'b0;
      default:   bit_d = bit_q;
    endcase
  end

  // Storage flop with synchronous clear to this bit's reset value.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      bit_q <= RST_BIT;
    end else begin
      bit_q <= bit_d;
    end
  end

  assign q_o = bit_q;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register with a Start/Busy/Done sequencer that repeats a shift/rotate op Amt times.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int unsigned      CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [MODE_W-1:0] Mode,
  input  logic [WIDTH-1:0]  I,
  input  logic              SIR,
  input  logic              SIL,
  input  logic              Start,
  input  logic [CNT_W-1:0]  Amt,
  output logic [WIDTH-1:0]  Q,
  output logic              SOR,
  output logic              SOL,
  output logic              Busy,
  output logic              Done
);

  usr_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MODE_W-1:0] op_q, op_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [MODE_W-1:0] eff_op_c;
  logic [WIDTH-1:0]  q_q;
  logic              rfill_c;
  logic              lfill_c;
  logic [WIDTH-1:0]  rsrc_c;
  logic [WIDTH-1:0]  lsrc_c;

  // Sequencer next state, step counter and effective op selection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    eff_op_c = MODE_HOLD;
    case (state_q)
      IDLE: begin
        eff_op_c = Mode;
        if (Start) begin
          if (is_multi(Mode)) begin
            op_d = Mode;
            if (Amt == CNT_W'(0)) begin
              eff_op_c = MODE_HOLD;
              state_d  = DONE;
            end else if (Amt == CNT_W'(1)) begin
              state_d = DONE;
            end else begin
              cnt_d   = Amt - CNT_W'(1);
              state_d = RUN;
            end
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        eff_op_c = op_q;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        eff_op_c = MODE_HOLD;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Sequencer registers; CLR aborts any op without a Done pulse.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= MODE_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Edge fill bits for right- and left-moving ops.
  always_comb begin
    rfill_c = SIR;
    case (eff_op_c)
      MODE_ROTR: rfill_c = q_q[0];
      MODE_ASR:  rfill_c = q_q[WIDTH-1];
      default:   rfill_c = SIR;
    endcase
    lfill_c = (eff_op_c == MODE_ROTL) ? q_q[WIDTH-1] : SIL;
  end

  assign rsrc_c = {rfill_c, q_q[WIDTH-1:1]};
  assign lsrc_c = {q_q[WIDTH-2:0], lfill_c};

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    usr_bit_cell #(
      .RST_BIT(RESET_VAL[gi])
    ) u_cell (
      .clk_i (CLK),
      .clr_i (CLR),
      .op_i  (eff_op_c),
      .rsrc_i(rsrc_c[gi]),
      .lsrc_i(lsrc_c[gi]),
      .ld_i  (I[gi]),
      .q_o   (q_q[gi])
    );
  end

  assign Q    = q_q;
  assign SOR  = q_q[0];
  assign SOL  = q_q[WIDTH-1];
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg (WIDTH=8, RESET_VAL=0).
module tb_universal_shift_reg;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_ROTR = 3'b100;
  localparam logic [2:0] M_ROTL = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_ZERO = 3'b111;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [2:0] Mode;
  logic [7:0] I;
  logic       SIR, SIL, Start;
  logic [3:0] Amt;
  logic [7:0] Q;
  logic       SOR, SOL, Busy, Done;

  int total = 0;
  int bad   = 0;

  universal_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .CLK(CLK), .CLR(CLR), .Mode(Mode), .I(I), .SIR(SIR), .SIL(SIL),
    .Start(Start), .Amt(Amt), .Q(Q), .SOR(SOR), .SOL(SOL), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       clr;
    logic [2:0] mode;
    logic [7:0] i;
    logic       sir;
    logic       sil;
    logic       start;
    logic [3:0] amt;
    logic [7:0] q;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic clr, logic [2:0] mode, logic [7:0] i, logic sir, logic sil,
                              logic start, logic [3:0] amt, logic [7:0] q, logic busy, logic done);
    vec_t v;
    v.clr = clr; v.mode = mode; v.i = i; v.sir = sir; v.sil = sil;
    v.start = start; v.amt = amt; v.q = q; v.busy = busy; v.done = done;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic clr, input logic [2:0] mode, input logic [7:0] i,
                       input logic sir, input logic sil, input logic start, input logic [3:0] amt);
    CLR = clr; Mode = mode; I = i; SIR = sir; SIL = sil; Start = start; Amt = amt;
  endtask

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] q, input logic busy, input logic done);
    chk({tag, ".Q"}, Q, q);
    chk({tag, ".Busy"}, 8'(Busy), 8'(busy));
    chk({tag, ".Done"}, 8'(Done), 8'(done));
    chk({tag, ".SOR"}, 8'(SOR), 8'(q[0]));
    chk({tag, ".SOL"}, 8'(SOL), 8'(q[7]));
  endtask

  initial begin
    drive(1'b1, M_LOAD, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0);
    #2;

    //          clr   mode    I      sir   sil   start amt    Q      busy  done
    vecs.push_back(mk(1'b1, M_LOAD, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, M_LOAD, 8'hA5, 1'b0, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, M_SHR,  8'h00, 1'b1, 1'b0, 1'b0, 4'd0, 8'hD2, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, M_LOAD, 8'hA5, 1'b0, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, M_SHL,  8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h4A, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, M_LOAD, 8'hA5, 1'b0, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, M_ASR,  8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'hD2, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, M_LOAD, 8'hA5, 1'b0, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, M_ROTL, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h4B, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, M_ZERO, 8'hFF, 1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, M_LOAD, 8'h3C, 1'b0, 1'b0, 1'b0, 4'd0, 8'h3C, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, M_SHR,  8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 8'h1E, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, M_ROTR, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 8'h0F, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, M_SHL,  8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 8'h1F, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, M_HOLD, 8'hFF, 1'b1, 1'b1, 1'b0, 4'd0, 8'h1F, 1'b0, 1'b0));
    // Multi-step ROTR x3 from A5; Mode/Start/Amt/I noise during RUN, Start ignored in DONE
    vecs.push_back(mk(1'b0, M_LOAD, 8'hA5, 1'b0, 1'b0, 1'b0, 4'd0, 8'hA5, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, M_ROTR, 8'h00, 1'b0, 1'b0, 1'b1, 4'd3, 8'hD2, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, M_ZERO, 8'hFF, 1'b1, 1'b1, 1'b1, 4'd7, 8'h69, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, M_LOAD, 8'hFF, 1'b0, 1'b0, 1'b1, 4'd1, 8'hB4, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, M_LOAD, 8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 8'hB4, 1'b0, 1'b0));
    // Amt=0 shift: no step, Done next cycle; then one-shot LOAD through the sequencer
    vecs.push_back(mk(1'b0, M_SHL,  8'h00, 1'b0, 1'b1, 1'b1, 4'd0, 8'hB4, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, M_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'hB4, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, M_LOAD, 8'h3C, 1'b0, 1'b0, 1'b1, 4'd0, 8'h3C, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, M_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h3C, 1'b0, 1'b0));
    // Amt=1 ASR: single step, Done right away
    vecs.push_back(mk(1'b0, M_ASR,  8'h00, 1'b0, 1'b0, 1'b1, 4'd1, 8'h1E, 1'b1, 1'b1));
    vecs.push_back(mk(1'b0, M_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 8'h1E, 1'b0, 1'b0));

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].clr, vecs[k].mode, vecs[k].i, vecs[k].sir, vecs[k].sil,
            vecs[k].start, vecs[k].amt);
      tick();
      chk_all($sformatf("vec%0d", k), vecs[k].q, vecs[k].busy, vecs[k].done);
    end

    // CLR aborts a running SHL x5 from FF on the third RUN edge
    drive(1'b0, M_LOAD, 8'hFF, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    chk_all("abort.load", 8'hFF, 1'b0, 1'b0);
    drive(1'b0, M_SHL, 8'h00, 1'b0, 1'b0, 1'b1, 4'd5);
    tick();
    chk_all("abort.s1", 8'hFE, 1'b1, 1'b0);
    drive(1'b0, M_HOLD, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    chk_all("abort.s2", 8'hFC, 1'b1, 1'b0);
    tick();
    chk_all("abort.s3", 8'hF8, 1'b1, 1'b0);
    CLR = 1'b1;
    tick();
    chk_all("abort.clr", 8'h00, 1'b0, 1'b0);
    CLR = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_all($sformatf("abort.after%0d", k), 8'h00, 1'b0, 1'b0);
    end

    // Start held high: ROTL x2 twice with one gap cycle
    drive(1'b0, M_LOAD, 8'h81, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    chk_all("held.load", 8'h81, 1'b0, 1'b0);
    drive(1'b0, M_ROTL, 8'h00, 1'b0, 1'b0, 1'b1, 4'd2);
    tick();
    chk_all("held.a1", 8'h03, 1'b1, 1'b0);
    tick();
    chk_all("held.a2", 8'h06, 1'b1, 1'b1);
    tick();
    chk_all("held.gap", 8'h06, 1'b0, 1'b0);
    tick();
    chk_all("held.b1", 8'h0C, 1'b1, 1'b0);
    tick();
    chk_all("held.b2", 8'h18, 1'b1, 1'b1);
    Start = 1'b0;
    tick();
    chk_all("held.end", 8'h18, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
